inst_buffer: RTL and testbench

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer.sv | 103 ++++++++++
 tb/tb_inst_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// Instruction buffer: a circular FIFO of {pc, inst} entries between icache fetch groups and decode.
// Define IBUF_DUAL_ISSUE_EN to enable the second output port (up to two pops per cycle).
module inst_buffer #(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [255:0] in_data,
    input  logic [3:0]   in_num,
    input  logic [31:0]  in_pc,
    output logic         in_ready,
    output logic         out0_valid,
    output logic         out1_valid,
    output logic [31:0]  out0_inst,
    output logic [31:0]  out1_inst,
    output logic [31:0]  out0_pc,
    output logic [31:0]  out1_pc,
    input  logic [1:0]   pop_num
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FILL_LIMIT = (AW+1)'(DEPTH - 8);

    logic [31:0]   instMem [DEPTH];
    logic [31:0]   pcMem   [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          doPush;
    logic [3:0]    pushNum;
    logic [1:0]    popNum;

    // Ready only looks at the registered count, so a full group always fits regardless of pops.
    assign in_ready   = (count_q <= FILL_LIMIT);
    assign out0_valid = (count_q != '0);
    assign out0_inst  = instMem[head_q];
    assign out0_pc    = pcMem[head_q];

`ifdef IBUF_DUAL_ISSUE_EN
    assign out1_valid = (count_q >= (AW+1)'(2));
    assign out1_inst  = instMem[head_q + AW'(1)];
    assign out1_pc    = pcMem[head_q + AW'(1)];
`else
    assign out1_valid = 1'b0;
    assign out1_inst  = 32'd0;
    assign out1_pc    = 32'd0;
`endif

    always_comb begin
        pushNum = (in_num > 4'd8) ? 4'd8 : in_num;
        doPush  = in_valid && in_ready && !flush;
        popNum  = 2'd0;
`ifdef IBUF_DUAL_ISSUE_EN
        if (pop_num != 2'd0 && out0_valid) begin
            popNum = (pop_num >= 2'd2 && out1_valid) ? 2'd2 : 2'd1;
        end
`else
        if (pop_num != 2'd0 && out0_valid) begin
            popNum = 2'd1;
        end
`endif
        head_d  = head_q + AW'(popNum);
        tail_d  = tail_q;
        count_d = count_q - (AW+1)'(popNum);
        if (doPush) begin
            tail_d  = tail_q + AW'(pushNum);
            count_d = count_d + (AW+1)'(pushNum);
        end
        // Flush wins over both the push and the pop of this cycle.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; the count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (doPush) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < pushNum) begin
                    instMem[tail_q + AW'(i)] <= in_data[32*i +: 32];
                    pcMem[tail_q + AW'(i)]   <= in_pc + 32'(4 * i);
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized and directed bench for inst_buffer, checked against a queue-based reference model.
// Follows the IBUF_DUAL_ISSUE_EN setting of the build.
module tb_inst_buffer;

    logic         clk;
    logic         resetn;
    logic         flush;
    logic         in_valid;
    logic [255:0] in_data;
    logic [3:0]   in_num;
    logic [31:0]  in_pc;
    logic         in_ready;
    logic         out0_valid;
    logic         out1_valid;
    logic [31:0]  out0_inst;
    logic [31:0]  out1_inst;
    logic [31:0]  out0_pc;
    logic [31:0]  out1_pc;
    logic [1:0]   pop_num;

`ifdef IBUF_DUAL_ISSUE_EN
    localparam int MAXPOP = 2;
`else
    localparam int MAXPOP = 1;
`endif
    localparam int DEPTH = 16;

    int nChecked = 0;
    int nFailed  = 0;
    bit lastAccepted;
    logic [31:0] mPc[$];
    logic [31:0] mInst[$];

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_num(in_num), .in_pc(in_pc),
        .in_ready(in_ready),
        .out0_valid(out0_valid), .out1_valid(out1_valid),
        .out0_inst(out0_inst), .out1_inst(out1_inst),
        .out0_pc(out0_pc), .out1_pc(out1_pc),
        .pop_num(pop_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecked++;
        assert (obs === exp) else begin
            nFailed++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // Compare every visible output against what the model queue says is buffered.
    task automatic checkOutput(input string tag);
        int sz;
        sz = mPc.size();
        check1({tag, "/in_ready"}, 32'(in_ready), 32'(DEPTH - sz >= 8));
        check1({tag, "/out0_valid"}, 32'(out0_valid), 32'(sz >= 1));
        if (sz >= 1) begin
            check1({tag, "/out0_pc"}, out0_pc, mPc[0]);
            check1({tag, "/out0_inst"}, out0_inst, mInst[0]);
        end
`ifdef IBUF_DUAL_ISSUE_EN
        check1({tag, "/out1_valid"}, 32'(out1_valid), 32'(sz >= 2));
        if (sz >= 2) begin
            check1({tag, "/out1_pc"}, out1_pc, mPc[1]);
            check1({tag, "/out1_inst"}, out1_inst, mInst[1]);
        end
`else
        check1({tag, "/out1_valid"}, 32'(out1_valid), 32'd0);
        check1({tag, "/out1_pc"}, out1_pc, 32'd0);
        check1({tag, "/out1_inst"}, out1_inst, 32'd0);
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check outputs.
    task automatic applyStimulus(input logic fl, input logic v, input logic [3:0] num,
                                 input logic [31:0] pc, input logic [255:0] data,
                                 input logic [1:0] pn, input string tag);
        int n;
        int p;
        bit acc;
        flush    = fl;
        in_valid = v;
        in_num   = num;
        in_pc    = pc;
        in_data  = data;
        pop_num  = pn;
        acc = v && (DEPTH - mPc.size() >= 8) && !fl;
        @(posedge clk);
        if (fl) begin
            mPc.delete();
            mInst.delete();
        end else begin
            p = int'(pn);
            if (p > MAXPOP) p = MAXPOP;
            if (p > mPc.size()) p = mPc.size();
            repeat (p) begin
                void'(mPc.pop_front());
                void'(mInst.pop_front());
            end
            if (acc) begin
                n = (int'(num) > 8) ? 8 : int'(num);
                for (int i = 0; i < n; i++) begin
                    mPc.push_back(pc + 32'(4 * i));
                    mInst.push_back(data[32*i +: 32]);
                end
            end
        end
        lastAccepted = acc;
        @(negedge clk);
        checkOutput(tag);
    endtask

    function automatic logic [255:0] randData();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [255:0] seqData;
        logic [31:0]  expPc;
        int           grp;
        int           cyc;
        int           popped;

        flush = 0; in_valid = 0; in_num = 0; in_pc = 0; in_data = '0; pop_num = 0;
        resetn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset");
        resetn = 1;
        @(negedge clk);
        checkOutput("postReset");

        // Full 8-word group from the reset vector
        for (int i = 0; i < 8; i++) seqData[32*i +: 32] = 32'h11 * 32'(i + 1);
        applyStimulus(0, 1, 4'd8, 32'hBFC00000, seqData, 2'd0, "fill8");
        check1("fill8/pc0", out0_pc, 32'hBFC00000);
        check1("fill8/inst0", out0_inst, 32'h11);
        check1("fill8/ready", 32'(in_ready), 32'd1);

        // Push 3 more: ready drops, further groups are ignored until drained
        applyStimulus(0, 1, 4'd3, 32'h00001000, randData(), 2'd0, "push3");
        check1("push3/ready", 32'(in_ready), 32'd0);
        applyStimulus(0, 1, 4'd8, 32'h00002000, randData(), 2'd0, "ignored");
        applyStimulus(0, 1, 4'd8, 32'h00002000, randData(), 2'd3, "drain");
        applyStimulus(0, 1, 4'd8, 32'h00002000, randData(), 2'd2, "drain");
        applyStimulus(0, 1, 4'd8, 32'h00002000, randData(), 2'd2, "drain");
        applyStimulus(0, 1, 4'd8, 32'h00002000, randData(), 2'd2, "drain");

        // Pop of 2 with a single entry left
        applyStimulus(1, 0, 4'd0, 32'h0, '0, 2'd0, "flushA");
        applyStimulus(0, 1, 4'd1, 32'h00003000, randData(), 2'd0, "one");
        applyStimulus(0, 0, 4'd0, 32'h0, '0, 2'd2, "underflow");
        check1("underflow/out0_valid", 32'(out0_valid), 32'd0);

        // Simultaneous push and pop
        applyStimulus(0, 1, 4'd5, 32'h00004000, randData(), 2'd0, "five");
        applyStimulus(0, 1, 4'd4, 32'h00005000, randData(), 2'd2, "pushPop");
        applyStimulus(0, 0, 4'd0, 32'h0, '0, 2'd0, "pushPopHold");

        // Flush with a push offered in the same cycle
        applyStimulus(1, 0, 4'd0, 32'h0, '0, 2'd0, "flushB");
        applyStimulus(0, 1, 4'd8, 32'h00006000, randData(), 2'd0, "eight");
        applyStimulus(0, 1, 4'd2, 32'h00007000, randData(), 2'd0, "ten");
        applyStimulus(1, 1, 4'd8, 32'h00008000, randData(), 2'd2, "flushPush");
        check1("flushPush/out0_valid", 32'(out0_valid), 32'd0);
        check1("flushPush/ready", 32'(in_ready), 32'd1);

        // Oversized in_num saturates to 8, zero writes nothing
        applyStimulus(0, 1, 4'd15, 32'h00009000, randData(), 2'd0, "num15");
        applyStimulus(0, 1, 4'd0, 32'h0000A000, randData(), 2'd1, "num0");

        // Reset asserted between edges while a group is offered
        in_valid = 1; in_num = 4'd8; in_pc = 32'h0000B000; in_data = randData(); pop_num = 0;
        #2 resetn = 0;
        #1;
        mPc.delete();
        mInst.delete();
        checkOutput("asyncReset");
        @(posedge clk);
        @(negedge clk);
        checkOutput("inReset");
        resetn = 1;
        in_valid = 0;
        @(negedge clk);
        checkOutput("resetRelease");

        // Wrap-around: 40 groups of 5 with continuous pops; PCs must advance by exactly 4
        grp = 0;
        cyc = 0;
        expPc = 32'h80000000;
        while ((grp < 40 || mPc.size() != 0) && cyc < 2000) begin
            popped = (mPc.size() < MAXPOP) ? mPc.size() : MAXPOP;
            if (popped >= 1) begin
                check1("wrap/seq0", out0_pc, expPc);
                expPc += 32'd4;
            end
`ifdef IBUF_DUAL_ISSUE_EN
            if (popped >= 2) begin
                check1("wrap/seq1", out1_pc, expPc);
                expPc += 32'd4;
            end
`endif
            applyStimulus(0, grp < 40, 4'd5, 32'h80000000 + 32'(20 * grp), randData(), 2'd2, "wrap");
            if (lastAccepted) grp++;
            cyc++;
        end
        if (cyc >= 2000) begin
            nChecked++;
            nFailed++;
            $display("[TB] FAIL wrap/timeout observed=%0d groups expected=40", grp);
        end
        check1("wrap/endPc", expPc, 32'h80000000 + 32'd800);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                          4'($urandom_range(0, 15)), $urandom & 32'hFFFFFFFC,
                          randData(), 2'($urandom_range(0, 3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecked, nFailed);
        $finish;
    end

endmodule
